timer_halt_initiator: RTL and testbench

Debug-side initiator of the timer halt handshake. It converts one-cycle halt/resume commands from the debug controller into the level-based `dbg_mode`/`halt_req` pair that the timer's counter control consumes, and tracks the returned `halt_ack`. It reports halt status, measures halt duration, and flags handshake failures with sticky error bits. It sits between the debug register interface and the timer's counter-control responder.

---
 rtl/timer_halt_initiator.sv | 140 ++++++++++++++
 tb/tb_timer_halt_initiator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_halt_initiator.sv
`default_nettype none
// ============================================================================
// timer_halt_initiator : debug-side halt/resume handshake initiator with
//                        ack timeout, ack-loss detection and halt duration.
// Revision: 1.0
// ============================================================================
module timer_halt_initiator #(
  parameter int TIMEOUT_W = 8,
  parameter int HCNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dbg_en,
  input  logic                 halt_cmd,
  input  logic                 resume_cmd,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 err_clr,
  input  logic                 halt_ack,
  output logic                 dbg_mode,
  output logic                 halt_req,
  output logic                 halted,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 ack_lost_err,
  output logic [HCNT_W-1:0]    halt_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2,
    ST_REL    = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] C_TMR_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [HCNT_W-1:0]    C_HCNT_ONE = {{(HCNT_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [TIMEOUT_W-1:0]  timer_q, timer_d;
  logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
  logic                  terr_q, terr_d;
  logic                  lerr_q, lerr_d;
  logic                  dbg_mode_q, dbg_mode_d;
  logic                  halt_req_q, halt_req_d;
  logic                  halted_q, halted_d;
  logic                  busy_q, busy_d;
  logic                  w_terr_set;
  logic                  w_lerr_set;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    hcnt_d     = hcnt_q;
    w_terr_set = 1'b0;
    w_lerr_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (halt_cmd && dbg_en && !resume_cmd) begin
          state_d = ST_REQ;
          timer_d = timeout_val;
        end
      end
      ST_REQ: begin
        // Losing the debugger aborts quietly; otherwise resume beats ack beats timeout.
        if (!dbg_en || resume_cmd) begin
          state_d = ST_REL;
        end else if (halt_ack) begin
          state_d = ST_HALTED;
          hcnt_d  = '0;
        end else if (timer_q == '0) begin
          state_d    = ST_REL;
          w_terr_set = 1'b1;
        end else begin
          timer_d = timer_q - C_TMR_ONE;
        end
      end
      ST_HALTED: begin
        if (!dbg_en || resume_cmd) begin
          state_d = ST_REL;
        end else if (!halt_ack) begin
          state_d    = ST_REL;
          w_lerr_set = 1'b1;
        end else if (hcnt_q != '1) begin
          hcnt_d = hcnt_q + C_HCNT_ONE;
        end
      end
      ST_REL: begin
        if (!halt_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A set event in the same cycle outranks the clear.
    terr_d     = w_terr_set | (terr_q & ~err_clr);
    lerr_d     = w_lerr_set | (lerr_q & ~err_clr);
    dbg_mode_d = dbg_en;
    halt_req_d = (state_d == ST_REQ) || (state_d == ST_HALTED);
    halted_d   = (state_d == ST_HALTED);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      hcnt_q     <= '0;
      terr_q     <= 1'b0;
      lerr_q     <= 1'b0;
      dbg_mode_q <= 1'b0;
      halt_req_q <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      hcnt_q     <= hcnt_d;
      terr_q     <= terr_d;
      lerr_q     <= lerr_d;
      dbg_mode_q <= dbg_mode_d;
      halt_req_q <= halt_req_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
    end
  end

  assign dbg_mode     = dbg_mode_q;
  assign halt_req     = halt_req_q;
  assign halted       = halted_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;
  assign ack_lost_err = lerr_q;
  assign halt_cycles  = hcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_halt_initiator.sv
`default_nettype none
// ============================================================================
// tb_timer_halt_initiator : directed bench with a phase-level reference model
//                           and a registered-ack responder.
// Revision: 1.0
// ============================================================================
module tb_timer_halt_initiator;

  localparam int TW   = 8;
  localparam int HW   = 4;
  localparam int HMAX = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          dbg_en;
  logic          halt_cmd;
  logic          resume_cmd;
  logic [TW-1:0] timeout_val;
  logic          err_clr;
  logic          halt_ack = 1'b0;
  logic          dbg_mode;
  logic          halt_req;
  logic          halted;
  logic          busy;
  logic          timeout_err;
  logic          ack_lost_err;
  logic [HW-1:0] halt_cycles;

  int n_vec = 0;
  int n_bad = 0;
  int ack_mode = 0;  // 0: responder acks normally, 1: responder never acks

  timer_halt_initiator #(.TIMEOUT_W(TW), .HCNT_W(HW)) dut (
    .clk          (clk),
    .rst          (rst),
    .dbg_en       (dbg_en),
    .halt_cmd     (halt_cmd),
    .resume_cmd   (resume_cmd),
    .timeout_val  (timeout_val),
    .err_clr      (err_clr),
    .halt_ack     (halt_ack),
    .dbg_mode     (dbg_mode),
    .halt_req     (halt_req),
    .halted       (halted),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .ack_lost_err (ack_lost_err),
    .halt_cycles  (halt_cycles)
  );

  always #5 clk = ~clk;

  // Responder: registers its acknowledge from halt_req while in debug mode.
  always @(posedge clk) begin
    if (rst) halt_ack <= 1'b0;
    else     halt_ack <= (ack_mode == 0) && halt_req && dbg_mode;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 requesting, 2 halted, 3 releasing.
  int m_phase = 0;
  int m_age   = 0;
  int m_tv    = 0;
  int m_dur   = 0;
  bit m_terr  = 0;
  bit m_lerr  = 0;
  bit m_dbgm  = 0;
  bit m_valid = 0;

  always @(negedge clk) begin
    bit tset, lset;
    if (m_valid) begin
      check("dbg_mode",     dbg_mode,     m_dbgm);
      check("halt_req",     halt_req,     (m_phase == 1 || m_phase == 2));
      check("halted",       halted,       (m_phase == 2));
      check("busy",         busy,         (m_phase != 0));
      check("timeout_err",  timeout_err,  m_terr);
      check("ack_lost_err", ack_lost_err, m_lerr);
      check("halt_cycles",  halt_cycles,  m_dur);
    end
    tset = 0;
    lset = 0;
    if (rst) begin
      m_phase = 0; m_age = 0; m_dur = 0;
      m_terr = 0; m_lerr = 0; m_dbgm = 0;
      m_valid = 1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (halt_cmd && dbg_en && !resume_cmd) begin
             m_phase = 1; m_tv = int'(timeout_val); m_age = 1;
           end
        1: if (!dbg_en || resume_cmd) m_phase = 3;
           else if (halt_ack) begin m_phase = 2; m_dur = 0; end
           else if (m_age == m_tv + 1) begin m_phase = 3; tset = 1; end
           else m_age++;
        2: if (!dbg_en || resume_cmd) m_phase = 3;
           else if (!halt_ack) begin m_phase = 3; lset = 1; end
           else if (m_dur < HMAX) m_dur++;
        default: if (!halt_ack) m_phase = 0;
      endcase
      if (err_clr) begin m_terr = 0; m_lerr = 0; end
      if (tset) m_terr = 1;
      if (lset) m_lerr = 1;
      m_dbgm = dbg_en;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    bit saw_halt;
    rst = 1; dbg_en = 1; halt_cmd = 0; resume_cmd = 0; err_clr = 0; timeout_val = 8'd20;
    tick(3);
    check("rst_halt_req", halt_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halt_cycles", halt_cycles, 0);
    check("rst_dbg_mode", dbg_mode, 0);
    rst = 0;
    tick(2);

    // Basic halt/resume
    halt_cmd = 1; tick; halt_cmd = 0;
    check("basic_req_c1", halt_req, 1);
    tick(2);
    check("basic_halted_c3", halted, 1);
    check("basic_hcyc_c3", halt_cycles, 0);
    tick(10);
    check("basic_hcyc_c13", halt_cycles, 10);
    resume_cmd = 1; tick; resume_cmd = 0;
    check("basic_req_off", halt_req, 0);
    check("basic_hcyc_rel", halt_cycles, 10);
    tick;
    check("basic_busy_m2", busy, 1);
    tick;
    check("basic_busy_m3", busy, 0);

    // Timeout with timeout_val=3
    ack_mode = 1; timeout_val = 8'd3;
    halt_cmd = 1; tick; halt_cmd = 0;
    hi = 0; saw_halt = 0;
    for (int i = 0; i < 10; i++) begin
      if (halt_req) hi++;
      if (halted) saw_halt = 1;
      tick;
    end
    check("to_req_cycles", hi, 4);
    check("to_never_halted", saw_halt, 0);
    check("to_err", timeout_err, 1);
    check("to_idle", busy, 0);
    err_clr = 1; tick; err_clr = 0;
    check("clr_terr", timeout_err, 0);

    // Ack lost while halted
    ack_mode = 0; timeout_val = 8'd20;
    halt_cmd = 1; tick; halt_cmd = 0;
    tick(4);
    ack_mode = 1; tick;
    check("al_still_halted", halted, 1);
    tick;
    check("al_err", ack_lost_err, 1);
    check("al_req_off", halt_req, 0);
    tick(2);

    // err_clr together with a new timeout event
    timeout_val = 8'd2;
    halt_cmd = 1; tick; halt_cmd = 0;
    tick(2);
    err_clr = 1; tick; err_clr = 0;
    check("clrset_terr", timeout_err, 1);
    check("clrset_lerr", ack_lost_err, 0);
    tick(2);
    err_clr = 1; tick; err_clr = 0;

    // Command conflicts
    halt_cmd = 1; resume_cmd = 1; tick; halt_cmd = 0; resume_cmd = 0;
    check("both_idle", busy, 0);
    dbg_en = 0; halt_cmd = 1; tick; halt_cmd = 0;
    check("nodbg_req", halt_req, 0);
    dbg_en = 1; tick(2);
    timeout_val = 8'd50;
    halt_cmd = 1; tick; halt_cmd = 0;
    resume_cmd = 1; tick; resume_cmd = 0;
    check("abort_req_off", halt_req, 0);
    check("abort_busy", busy, 1);
    check("abort_no_err", timeout_err, 0);
    tick(2);
    check("abort_idle", busy, 0);
    ack_mode = 0;

    // Saturation
    halt_cmd = 1; tick; halt_cmd = 0;
    tick(2);
    tick(40);
    check("sat_hcyc", halt_cycles, HMAX);
    resume_cmd = 1; tick; resume_cmd = 0;
    tick(3);
    check("sat_kept", halt_cycles, HMAX);
    check("sat_idle", busy, 0);

    // Debugger detaches while halted
    halt_cmd = 1; tick; halt_cmd = 0;
    tick(2);
    dbg_en = 0; tick;
    check("detach_req_off", halt_req, 0);
    tick(3);
    check("detach_idle", busy, 0);
    dbg_en = 1; tick(2);

    // Reset mid-halt, then a clean halt
    halt_cmd = 1; tick; halt_cmd = 0;
    tick(3);
    rst = 1; tick; rst = 0;
    check("rmh_req", halt_req, 0);
    check("rmh_halted", halted, 0);
    check("rmh_busy", busy, 0);
    check("rmh_hcyc", halt_cycles, 0);
    check("rmh_dbg_mode", dbg_mode, 0);
    tick(3);
    halt_cmd = 1; tick; halt_cmd = 0;
    tick(2);
    check("rmh_rehalt", halted, 1);
    resume_cmd = 1; tick; resume_cmd = 0;
    tick(3);
    check("rmh_done", busy, 0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
